// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state encoding and condition-code constants
package cpu_pkg;
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_RESOLVE = 2'b01,
        ST_HALT    = 2'b10
    } state_t;
    localparam logic [2:0] CC_EQ = 3'b000;
    localparam logic [2:0] CC_LT = 3'b001;
    localparam logic [2:0] CC_LE = 3'b010;
    localparam logic [2:0] CC_NE = 3'b011;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else q <= clear ? '0 : (inc && q != '1) ? q + 1'b1 : q;
endmodule

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: program counter owner; resolves decode branches against the
// condition flag one cycle after acceptance and redirects fetch when taken
module branch_pc_ctrl
    import cpu_pkg::*;
#(
    parameter int              AW       = 8,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt,
    input  logic             br_valid,
    input  logic             br_uncond,
    input  logic [AW-1:0]    br_target,
    input  logic             cond_flag,
    output logic [AW-1:0]    pc,
    output logic             fetch_en,
    output logic             br_ack,
    output logic             br_taken,
    output logic             flush,
    output logic [CNT_W-1:0] taken_cnt
);
    state_t        state;
    logic [AW-1:0] tgt;
    logic          unc;
    logic          taken;
    logic          resolve;
    logic [AW-1:0] pc_inc;
    assign taken   = unc | cond_flag;
    assign resolve = state == ST_RESOLVE && !stall;
    assign pc_inc  = pc + 1'b1;
    // pc advances only once the current address has actually been fetched
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            fetch_en <= 1'b0;
            br_ack   <= 1'b0;
            br_taken <= 1'b0;
            flush    <= 1'b0;
            tgt      <= '0;
            unc      <= 1'b0;
        end else begin
            br_ack   <= 1'b0;
            br_taken <= 1'b0;
            flush    <= 1'b0;
            case (state)
                ST_RUN: if (!stall) begin
                    if (br_valid && !br_ack) begin
                        tgt      <= br_target;
                        unc      <= br_uncond;
                        fetch_en <= 1'b0;
                        state    <= ST_RESOLVE;
                    end else if (halt) begin
                        fetch_en <= 1'b0;
                        state    <= ST_HALT;
                    end else begin
                        if (fetch_en) pc <= pc_inc;
                        fetch_en <= 1'b1;
                    end
                end
                ST_RESOLVE: if (!stall) begin
                    pc       <= taken ? tgt : pc_inc;
                    br_ack   <= 1'b1;
                    br_taken <= taken;
                    flush    <= taken;
                    fetch_en <= 1'b1;
                    state    <= ST_RUN;
                end
                default: fetch_en <= 1'b0;
            endcase
        end
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (resolve && taken),
        .clear(1'b0),
        .q    (taken_cnt)
    );
endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb_branch_pc_ctrl: directed vectors with hand-computed expectations
module tb_branch_pc_ctrl;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       stall = 0, halt = 0, br_valid = 0, br_uncond = 0, cond_flag = 0;
    logic [7:0] br_target = 0;
    logic [7:0] pc, taken_cnt;
    logic       fetch_en, br_ack, br_taken, flush;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    branch_pc_ctrl #(.AW(8), .RESET_PC(8'h00), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
        .br_valid(br_valid), .br_uncond(br_uncond), .br_target(br_target),
        .cond_flag(cond_flag), .pc(pc), .fetch_en(fetch_en), .br_ack(br_ack),
        .br_taken(br_taken), .flush(flush), .taken_cnt(taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_branch(input logic [7:0] t, input logic u, input logic f);
        br_valid = 1; br_target = t; br_uncond = u; cond_flag = f;
        @(negedge clk);
        @(negedge clk);
        br_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, 8'h00);
        check("rst_fe", fetch_en, 0);
        check("rst_ack", br_ack, 0);
        check("rst_cnt", taken_cnt, 0);
        rst_n = 1;
        // 1: free-running fetch
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("seq_pc", pc, i);
            check("seq_fe", fetch_en, 1);
            check("seq_ack", br_ack, 0);
            check("seq_flush", flush, 0);
        end
        @(negedge clk);
        @(negedge clk);
        check("pc5", pc, 8'h05);
        // 2: conditional taken
        br_valid = 1; br_target = 8'h40; br_uncond = 0; cond_flag = 1;
        @(negedge clk);
        check("t2_fe", fetch_en, 0);
        check("t2_pchold", pc, 8'h05);
        @(negedge clk);
        check("t2_pc", pc, 8'h40);
        check("t2_ack", br_ack, 1);
        check("t2_taken", br_taken, 1);
        check("t2_flush", flush, 1);
        check("t2_fe1", fetch_en, 1);
        check("t2_cnt", taken_cnt, 1);
        @(negedge clk);
        check("t2_ignore_pc", pc, 8'h41);
        check("t2_ack0", br_ack, 0);
        check("t2_flush0", flush, 0);
        check("t2_ignore_fe", fetch_en, 1);
        // 3: conditional not taken
        br_target = 8'h70; cond_flag = 0;
        @(negedge clk);
        check("t3_fe", fetch_en, 0);
        @(negedge clk);
        check("t3_pc", pc, 8'h42);
        check("t3_ack", br_ack, 1);
        check("t3_taken", br_taken, 0);
        check("t3_flush", flush, 0);
        check("t3_cnt", taken_cnt, 1);
        br_valid = 0;
        @(negedge clk);
        // 4: wrap and saturation
        do_branch(8'hFE, 1, 0);
        check("t4_pcff", pc, 8'hFF);
        check("t4_cnt2", taken_cnt, 2);
        @(negedge clk);
        check("t4_wrap", pc, 8'h00);
        for (int i = 0; i < 252; i++) do_branch(8'h10, 1, 0);
        check("t4_cnt254", taken_cnt, 8'hFE);
        do_branch(8'h10, 0, 1);
        check("t4_cnt255", taken_cnt, 8'hFF);
        br_valid = 1; br_target = 8'h30; br_uncond = 1;
        @(negedge clk);
        @(negedge clk);
        check("t4_sat_taken", br_taken, 1);
        check("t4_sat", taken_cnt, 8'hFF);
        br_valid = 0;
        @(negedge clk);
        // 5: stall in RESOLVE
        check("t5_pre_pc", pc, 8'h31);
        br_valid = 1; br_target = 8'h80; br_uncond = 0; cond_flag = 0;
        @(negedge clk);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cond_flag = ~cond_flag;
            @(negedge clk);
            check("t5_pc", pc, 8'h31);
            check("t5_fe", fetch_en, 0);
            check("t5_ack", br_ack, 0);
        end
        stall = 0; cond_flag = 1;
        @(negedge clk);
        check("t5_redirect", pc, 8'h80);
        check("t5_ack1", br_ack, 1);
        check("t5_flush", flush, 1);
        br_valid = 0;
        @(negedge clk);
        // 6: branch beats halt, then HALT absorbs
        br_valid = 1; halt = 1; br_uncond = 1; br_target = 8'h20;
        @(negedge clk);
        check("t6_fe0", fetch_en, 0);
        @(negedge clk);
        check("t6_pc", pc, 8'h20);
        check("t6_ack", br_ack, 1);
        @(negedge clk);
        check("t6_halt_fe", fetch_en, 0);
        check("t6_halt_pc", pc, 8'h20);
        br_valid = 0; halt = 0;
        for (int i = 0; i < 3; i++) begin
            br_valid = i[0];
            @(negedge clk);
            check("t6_abs_pc", pc, 8'h20);
            check("t6_abs_fe", fetch_en, 0);
            check("t6_abs_ack", br_ack, 0);
        end
        br_valid = 0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t6_rerun_pc", pc, 8'h02);
        br_valid = 1; br_uncond = 1; br_target = 8'h55;
        @(negedge clk);
        check("t6_resolve_fe", fetch_en, 0);
        rst_n = 0;
        #1;
        check("t6_arst_pc", pc, 8'h00);
        check("t6_arst_fe", fetch_en, 0);
        check("t6_arst_cnt", taken_cnt, 0);
        @(negedge clk);
        check("t6_noack", br_ack, 0);
        check("t6_noflush", flush, 0);
        br_valid = 0;
        rst_n = 1;
        @(negedge clk);
        check("t6_rel_pc", pc, 8'h00);
        check("t6_rel_fe", fetch_en, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end
endmodule
